// File: rtl/audio_router_xfade.sv
// Audio routing matrix: every output picks any input channel or mute and
// crossfades linearly over 2^FADE_LOG2 sample strobes on each route change.
module audio_router_xfade #(
   parameter int BITSIZE   = 16,
   parameter int NUM_IN    = 11,
   parameter int NUM_OUT   = 12,
   parameter int SELW      = $clog2(NUM_IN + 1),
   parameter int FADE_LOG2 = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sample_strobe,
   input  logic [NUM_IN*BITSIZE-1:0]  in_bus,
   input  logic [NUM_OUT*SELW-1:0]    sel_bus,
   output logic [NUM_OUT*BITSIZE-1:0] out_bus,
   output logic [NUM_OUT-1:0]         busy
);

   localparam int L  = 1 << FADE_LOG2;
   localparam int KW = FADE_LOG2 + 1;
   localparam int AW = BITSIZE + FADE_LOG2 + 2;

   typedef enum logic {IDLE, FADE} state_t;

   // Source 0 is the mute route
   logic signed [BITSIZE-1:0] src [NUM_IN+1];

   assign src[0] = '0;

   for (genvar i = 1; i <= NUM_IN; i++) begin : g_src
      assign src[i] = in_bus[i*BITSIZE-1 -: BITSIZE];
   end

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      logic [SELW-1:0]           sel_raw;
      logic [SELW-1:0]           sel_m;
      logic [SELW-1:0]           to_s;
      logic [SELW-1:0]           cur_sel_q, cur_sel_d;
      logic [SELW-1:0]           tgt_sel_q, tgt_sel_d;
      logic [KW-1:0]             k_q, k_d;
      logic [KW-1:0]             kk;
      state_t                    state_q, state_d;
      logic signed [BITSIZE-1:0] out_q, out_d;
      logic                      busy_q;
      logic                      start;
      logic signed [AW-1:0]      a_x, b_x, wa, wb, acc;

      assign sel_raw = sel_bus[(j+1)*SELW-1 -: SELW];
      assign sel_m   = (sel_raw > SELW'(NUM_IN)) ? '0 : sel_raw;
      assign start   = (state_q == IDLE) && (sel_m != cur_sel_q);

      // k_q holds the blend index for the next strobe; a new fade uses 1
      assign kk   = (state_q == IDLE) ? KW'(1) : k_q;
      assign to_s = (state_q == IDLE) ? sel_m : tgt_sel_q;

      assign a_x = AW'(src[cur_sel_q]);
      assign b_x = AW'(src[to_s]);
      assign wa  = AW'(KW'(L) - kk);
      assign wb  = AW'(kk);
      assign acc = a_x * wa + b_x * wb;

      always_comb begin
         cur_sel_d = cur_sel_q;
         tgt_sel_d = tgt_sel_q;
         k_d       = k_q;
         state_d   = state_q;
         out_d     = out_q;
         if (sample_strobe) begin
            if ((state_q == IDLE) && !start) begin
               out_d = src[cur_sel_q];
            end else begin
               out_d     = BITSIZE'(acc >>> FADE_LOG2);
               tgt_sel_d = to_s;
               if (kk == KW'(L)) begin
                  cur_sel_d = to_s;
                  k_d       = '0;
                  state_d   = IDLE;
               end else begin
                  k_d     = kk + KW'(1);
                  state_d = FADE;
               end
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cur_sel_q <= '0;
            tgt_sel_q <= '0;
            k_q       <= '0;
            state_q   <= IDLE;
            out_q     <= '0;
            busy_q    <= 1'b0;
         end else begin
            cur_sel_q <= cur_sel_d;
            tgt_sel_q <= tgt_sel_d;
            k_q       <= k_d;
            state_q   <= state_d;
            out_q     <= out_d;
            busy_q    <= (state_d == FADE);
         end
      end

      assign out_bus[(j+1)*BITSIZE-1 -: BITSIZE] = out_q;
      assign busy[j] = busy_q;
   end

endmodule

// File: tb/tb_audio_router_xfade.sv
// Bench for audio_router_xfade: a 4-strobe fade instance and an instant-switch
// instance, checked against a per-strobe arithmetic model plus literal values.
module tb_audio_router_xfade;

   localparam int B  = 16;
   localparam int NI = 11;
   localparam int NO = 12;
   localparam int SW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            sample_strobe;
   logic [NI*B-1:0] in_bus;
   logic [NO*SW-1:0] sel_a, sel_b;
   logic [NO*B-1:0] out_a, out_b;
   logic [NO-1:0]   busy_a, busy_b;

   int ins [1:NI];
   int sel_av [NO];
   int sel_bv [NO];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always_comb begin
      in_bus = '0;
      for (int i = 1; i <= NI; i++) in_bus[(i-1)*B +: B] = B'(ins[i]);
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int j = 0; j < NO; j++) begin
         sel_a[j*SW +: SW] = SW'(sel_av[j]);
         sel_b[j*SW +: SW] = SW'(sel_bv[j]);
      end
   end

   audio_router_xfade #(
      .BITSIZE(B), .NUM_IN(NI), .NUM_OUT(NO), .FADE_LOG2(2)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
      .in_bus(in_bus), .sel_bus(sel_a), .out_bus(out_a), .busy(busy_a)
   );

   audio_router_xfade #(
      .BITSIZE(B), .NUM_IN(NI), .NUM_OUT(NO), .FADE_LOG2(0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
      .in_bus(in_bus), .sel_bus(sel_b), .out_bus(out_b), .busy(busy_b)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int oa(input int j);
      return int'($signed(out_a[j*B +: B]));
   endfunction

   function automatic int ob(input int j);
      return int'($signed(out_b[j*B +: B]));
   endfunction

   // ---------------- behavioural model ----------------
   int Ls [2] = '{4, 1};
   int m_cur [2][NO];
   int m_tgt [2][NO];
   int m_pos [2][NO];
   int m_out [2][NO];
   bit m_fade [2][NO];

   function automatic int fdiv(input int n, input int d);
      int q;
      q = n / d;
      if ((n % d) != 0 && n < 0) q--;
      return q;
   endfunction

   function automatic int msrc(input int s);
      return (s >= 1 && s <= NI) ? ins[s] : 0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int j = 0; j < NO; j++) begin
            m_cur[d][j] = 0; m_tgt[d][j] = 0; m_pos[d][j] = 0;
            m_out[d][j] = 0; m_fade[d][j] = 1'b0;
         end
   endtask

   task automatic model_step();
      int s, L;
      for (int d = 0; d < 2; d++) begin
         L = Ls[d];
         for (int j = 0; j < NO; j++) begin
            s = (d == 0) ? sel_av[j] : sel_bv[j];
            if (s > NI) s = 0;
            if (!m_fade[d][j] && s != m_cur[d][j]) begin
               m_tgt[d][j] = s;
               m_pos[d][j] = 1;
               m_fade[d][j] = 1'b1;
            end
            if (m_fade[d][j]) begin
               m_out[d][j] = fdiv(msrc(m_cur[d][j]) * (L - m_pos[d][j])
                                  + msrc(m_tgt[d][j]) * m_pos[d][j], L);
               if (m_pos[d][j] == L) begin
                  m_cur[d][j] = m_tgt[d][j];
                  m_fade[d][j] = 1'b0;
               end else begin
                  m_pos[d][j]++;
               end
            end else begin
               m_out[d][j] = msrc(m_cur[d][j]);
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (sample_strobe) model_step();
   end

   // Every cycle: all outputs of both instances against the model
   initial forever begin
      @(negedge clk);
      for (int j = 0; j < NO; j++) begin
         chk($sformatf("mdl out_a[%0d]", j), oa(j), m_out[0][j]);
         chk($sformatf("mdl busy_a[%0d]", j), int'(busy_a[j]), int'(m_fade[0][j]));
         chk($sformatf("mdl out_b[%0d]", j), ob(j), m_out[1][j]);
         chk($sformatf("mdl busy_b[%0d]", j), int'(busy_b[j]), int'(m_fade[1][j]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic strobe();
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
   endtask

   int exp1 [4] = '{'h1000, 'h2000, 'h3000, 'h4000};
   int exp2 [4] = '{-1, -2, -3, -3};

   initial begin
      rst_n = 1'b0;
      sample_strobe = 1'b0;
      for (int i = 1; i <= NI; i++) ins[i] = 0;
      for (int j = 0; j < NO; j++) begin
         sel_av[j] = 0;
         sel_bv[j] = 0;
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset out_a", int'(|out_a), 0);
      chk("reset busy_a", int'(|busy_a), 0);

      // fade from mute on out1
      ins[1] = 'h4000;
      sel_av[0] = 1;
      for (int n = 0; n < 4; n++) begin
         strobe();
         chk($sformatf("mute fade out1 #%0d", n), oa(0), exp1[n]);
         chk($sformatf("mute fade busy1 #%0d", n), int'(busy_a[0]), (n < 3) ? 1 : 0);
      end

      // floor on negative blends, out2
      ins[2] = -3;
      sel_av[1] = 2;
      for (int n = 0; n < 4; n++) begin
         strobe();
         chk($sformatf("neg fade out2 #%0d", n), oa(1), exp2[n]);
      end

      // mid-fade reselect on out3
      ins[3] = 'h0800;
      sel_av[2] = 1;
      repeat (4) strobe();
      chk("reselect settle out3", oa(2), 'h4000);
      sel_av[2] = 2;
      strobe();
      chk("reselect k1 out3", oa(2), 12287);
      sel_av[2] = 3;
      strobe();
      chk("reselect k2 out3", oa(2), 'h1FFE);
      strobe();
      strobe();
      chk("reselect done out3", oa(2), -3);
      chk("reselect done busy3", int'(busy_a[2]), 0);
      strobe();
      chk("refade start out3", oa(2), 509);
      chk("refade start busy3", int'(busy_a[2]), 1);
      repeat (10) @(negedge clk);
      chk("freeze out3", oa(2), 509);
      chk("freeze busy3", int'(busy_a[2]), 1);
      strobe();
      chk("after freeze out3", oa(2), 1022);
      strobe();
      strobe();
      chk("refade done out3", oa(2), 'h0800);

      // out-of-range selector maps onto mute: no fade
      sel_av[3] = 15;
      sel_bv[0] = 15;
      strobe();
      chk("sel15 out4", oa(3), 0);
      chk("sel15 busy4", int'(busy_a[3]), 0);
      chk("sel15 out_b1", ob(0), 0);
      chk("sel15 busy_b1", int'(busy_b[0]), 0);

      // instant switch
      ins[5] = 'h1234;
      sel_bv[0] = 5;
      strobe();
      chk("instant out_b1", ob(0), 'h1234);
      chk("instant busy_b1", int'(busy_b[0]), 0);
      repeat (2) @(negedge clk);
      chk("instant hold busy_b", int'(|busy_b), 0);

      // two outputs fading in lockstep
      ins[4] = 'h0400;
      ins[6] = -'h0400;
      sel_av[0] = 4;
      sel_av[11] = 6;
      strobe();
      chk("indep k1 out1", oa(0), 'h3100);
      chk("indep k1 out12", oa(11), -256);
      chk("indep k1 busy", int'(busy_a), 'h801);
      repeat (3) strobe();
      chk("indep done out1", oa(0), 'h0400);
      chk("indep done out12", oa(11), -'h0400);
      chk("indep done busy", int'(|busy_a), 0);

      // asynchronous reset in the middle of a fade
      sel_av[4] = 3;
      strobe();
      chk("pre-reset busy5", int'(busy_a[4]), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_a", int'(|out_a), 0);
      chk("async rst busy_a", int'(|busy_a), 0);
      chk("async rst out_b", int'(|out_b), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      strobe();
      chk("post-reset busy5", int'(busy_a[4]), 1);
      chk("post-reset out5", oa(4), 'h0200);
      repeat (5) strobe();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
